// File: rtl/decode_hazard_ctrl_if.sv
// Decode <-> interlock controller bundle: decoded instruction fields and control
// inputs from decode, stall/issue/bubble decisions and status back to the pipeline.
interface decode_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             insn_valid;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             ext_stall;
    logic             flush;
    logic             stall;
    logic             issue;
    logic             bubble;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output insn_valid, opcode, func, rs, rt, rd, ext_stall, flush,
        input  stall, issue, bubble, busy, stall_cnt
    );

    modport slave (
        input  insn_valid, opcode, func, rs, rt, rd, ext_stall, flush,
        output stall, issue, bubble, busy, stall_cnt
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock: classifies the decoded MIPS instruction, tracks destination
// registers of in-flight instructions and stalls decode on read-after-write hazards.
module decode_hazard_ctrl #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    decode_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
    } sb_entry_t;

    sb_entry_t        sb [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;
    logic             reads_rs;
    logic             reads_rt;
    logic [4:0]       dst;
    logic             has_dst;
    logic             hazard;
    logic             stall;
    logic             issue;
    logic             busy;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        dst      = 5'd0;
        case (bus.opcode) inside
            6'h00: begin
                reads_rs = 1'b1;
                if (bus.func != 6'h08) begin
                    reads_rt = 1'b1;
                    dst      = bus.rd;
                end
            end
            6'h03: dst = 5'd31;
            6'h04, 6'h05, [6'h28:6'h2B]: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            6'h06, 6'h07: reads_rs = 1'b1;
            [6'h08:6'h0F], [6'h20:6'h25]: begin
                reads_rs = 1'b1;
                dst      = bus.rt;
            end
            default: ;
        endcase
    end

    assign has_dst = (dst != 5'd0);

    // The oldest entry is skipped when the register file writes before it is read.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb[i].v && (sb[i].dst != 5'd0) && !(WB_BYPASS && (i == DEPTH - 1)) &&
                ((reads_rs && (sb[i].dst == bus.rs)) || (reads_rt && (sb[i].dst == bus.rt))))
                hazard = 1'b1;
        end
        hazard = hazard & bus.insn_valid;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            busy = busy | sb[i].v;
    end

    assign stall         = hazard | bus.ext_stall;
    assign issue         = bus.insn_valid & ~stall & ~bus.flush;
    assign bus.stall     = stall;
    assign bus.issue     = issue;
    assign bus.bubble    = ~bus.ext_stall & ~issue;
    assign bus.busy      = busy;
    assign bus.stall_cnt = stall_cnt_q;

    // NOTE: sequential state is written only with non-blocking assignments.
    // NOTE: the scoreboard is a few flops, not a RAM, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                sb[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++)
                sb[i].v <= 1'b0;
        end else if (!bus.ext_stall) begin
            for (int i = DEPTH - 1; i > 0; i--)
                sb[i] <= sb[i-1];
            sb[0] <= issue ? sb_entry_t'{v: has_dst, dst: dst} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: three configurations share one stimulus stream and are
// checked every cycle against a register-age model, plus hand-computed directed checks.
module tb_decode_hazard_ctrl;
    localparam int N     = 3;
    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       insn_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic [4:0] rd = '0;
    logic       ext_stall = 1'b0;
    logic       flush = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    // dut0: WB bypass, dut1: no bypass, dut2: WB bypass with a 4-bit counter
    decode_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
    decode_hazard_ctrl_if #(.CNT_W(16)) bus1 ();
    decode_hazard_ctrl_if #(.CNT_W(4))  bus2 ();

    decode_hazard_ctrl #(.DEPTH(DEPTH), .WB_BYPASS(1'b1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    decode_hazard_ctrl #(.DEPTH(DEPTH), .WB_BYPASS(1'b0), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decode_hazard_ctrl #(.DEPTH(DEPTH), .WB_BYPASS(1'b1), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.insn_valid = insn_valid; assign bus1.insn_valid = insn_valid; assign bus2.insn_valid = insn_valid;
    assign bus0.opcode = opcode;         assign bus1.opcode = opcode;         assign bus2.opcode = opcode;
    assign bus0.func = func;             assign bus1.func = func;             assign bus2.func = func;
    assign bus0.rs = rs;                 assign bus1.rs = rs;                 assign bus2.rs = rs;
    assign bus0.rt = rt;                 assign bus1.rt = rt;                 assign bus2.rt = rt;
    assign bus0.rd = rd;                 assign bus1.rd = rd;                 assign bus2.rd = rd;
    assign bus0.ext_stall = ext_stall;   assign bus1.ext_stall = ext_stall;   assign bus2.ext_stall = ext_stall;
    assign bus0.flush = flush;           assign bus1.flush = flush;           assign bus2.flush = flush;

    logic        o_stall [N];
    logic        o_issue [N];
    logic        o_bubble[N];
    logic        o_busy  [N];
    logic [15:0] o_cnt   [N];

    assign o_stall[0] = bus0.stall;   assign o_stall[1] = bus1.stall;   assign o_stall[2] = bus2.stall;
    assign o_issue[0] = bus0.issue;   assign o_issue[1] = bus1.issue;   assign o_issue[2] = bus2.issue;
    assign o_bubble[0] = bus0.bubble; assign o_bubble[1] = bus1.bubble; assign o_bubble[2] = bus2.bubble;
    assign o_busy[0] = bus0.busy;     assign o_busy[1] = bus1.busy;     assign o_busy[2] = bus2.busy;
    assign o_cnt[0] = bus0.stall_cnt; assign o_cnt[1] = bus1.stall_cnt; assign o_cnt[2] = {12'd0, bus2.stall_cnt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit use_rs;
        bit use_rt;
        int dst;
    } cls_t;

    localparam bit MWB [N] = '{1'b1, 1'b0, 1'b1};
    localparam int MMAX[N] = '{65535, 65535, 15};

    int   age_dst[N][DEPTH];   // destination written by the instruction issued a+1 cycles ago, 0 = none
    int   m_cnt[N];
    bit   m_stall[N];
    bit   m_issue[N];
    cls_t m_cls;

    function automatic cls_t classify(input int op, input int fn, input int s_t, input int d);
        cls_t c;
        c = '{0, 0, 0};
        if (op == 0) begin
            c.use_rs = 1;
            if (fn != 8) begin c.use_rt = 1; c.dst = d; end
        end else if (op == 3) c.dst = 31;
        else if (op == 4 || op == 5 || (op >= 40 && op <= 43)) begin c.use_rs = 1; c.use_rt = 1; end
        else if (op == 6 || op == 7) c.use_rs = 1;
        else if ((op >= 8 && op <= 15) || (op >= 32 && op <= 37)) begin c.use_rs = 1; c.dst = s_t; end
        return c;
    endfunction

    function automatic bit model_hazard(input int k, input cls_t c);
        for (int a = 0; a < DEPTH; a++) begin
            if (MWB[k] && a == DEPTH - 1) continue;
            if (age_dst[k][a] != 0 &&
                ((c.use_rs && age_dst[k][a] == int'(rs)) || (c.use_rt && age_dst[k][a] == int'(rt))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            for (int a = 0; a < DEPTH; a++) age_dst[k][a] = 0;
        end
    endtask

    always begin
        @(negedge clk);
        if (!rst_n) model_reset();
        m_cls = classify(int'(opcode), int'(func), int'(rt), int'(rd));
        for (int k = 0; k < N; k++) begin
            bit any;
            any = 0;
            for (int a = 0; a < DEPTH; a++) if (age_dst[k][a] != 0) any = 1;
            m_stall[k] = (insn_valid && model_hazard(k, m_cls)) || ext_stall;
            m_issue[k] = insn_valid && !m_stall[k] && !flush;
            check($sformatf("cyc_stall_d%0d", k), 32'(o_stall[k]), 32'(m_stall[k]));
            check($sformatf("cyc_issue_d%0d", k), 32'(o_issue[k]), 32'(m_issue[k]));
            check($sformatf("cyc_bubble_d%0d", k), 32'(o_bubble[k]), 32'(!ext_stall && !m_issue[k]));
            check($sformatf("cyc_busy_d%0d", k), 32'(o_busy[k]), 32'(any));
            check($sformatf("cyc_cnt_d%0d", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            for (int k = 0; k < N; k++) begin
                if (m_stall[k] && m_cnt[k] < MMAX[k]) m_cnt[k]++;
                if (flush) begin
                    for (int a = 0; a < DEPTH; a++) age_dst[k][a] = 0;
                end else if (!ext_stall) begin
                    for (int a = DEPTH - 1; a > 0; a--) age_dst[k][a] = age_dst[k][a-1];
                    age_dst[k][0] = m_issue[k] ? m_cls.dst : 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Apply fields, then wait 2 ns so combinational outputs settle well before the next edge.
    task automatic put(input bit v, input bit [5:0] op, input bit [5:0] fn, input bit [4:0] s,
                       input bit [4:0] t, input bit [4:0] d, input bit es, input bit fl);
        insn_valid = v; opcode = op; func = fn; rs = s; rt = t; rd = d;
        ext_stall = es; flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int k, input bit s, input bit i, input bit b);
        check($sformatf("%s_stall_d%0d", nm, k), 32'(o_stall[k]), 32'(s));
        check($sformatf("%s_issue_d%0d", nm, k), 32'(o_issue[k]), 32'(i));
        check($sformatf("%s_bubble_d%0d", nm, k), 32'(o_bubble[k]), 32'(b));
    endtask

    task automatic drain();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) check($sformatf("drain_busy_d%0d", k), 32'(o_busy[k]), 0);
    endtask

    initial begin
        // reset state: stall follows ext_stall, issue follows insn_valid
        put(1, 6'h08, 0, 0, 5, 0, 1, 0);
        for (int k = 0; k < N; k++) begin
            expect_out("rst_ext", k, 1, 0, 0);
            check($sformatf("rst_busy_d%0d", k), 32'(o_busy[k]), 0);
            check($sformatf("rst_cnt_d%0d", k), 32'(o_cnt[k]), 0);
        end
        put(1, 6'h08, 0, 0, 5, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("rst_run", k, 0, 1, 0);
        tick(); tick();
        rst_n = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // T1/T2: addi r5,r0,1 ; add r6,r5,r5
        put(1, 6'h08, 0, 0, 5, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t1_addi", k, 0, 1, 0);
        tick();
        put(1, 6'h00, 6'h20, 5, 5, 6, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t1_c1", k, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h20, 5, 5, 6, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t1_c2", k, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h20, 5, 5, 6, 0, 0);
        expect_out("t1_c3", 0, 0, 1, 0);
        expect_out("t2_c3", 1, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h20, 5, 5, 6, 0, 0);
        expect_out("t2_c4", 1, 0, 1, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_cnt_d0", 32'(o_cnt[0]), 2);
        check("t2_cnt_d1", 32'(o_cnt[1]), 3);
        check("t1_cnt_d2", 32'(o_cnt[2]), 2);
        drain();

        // T3: writes to r0 never interlock; store->load sharing r4 has no dst
        put(1, 6'h08, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t3_addi_r0", k, 0, 1, 0);
        tick();
        put(1, 6'h00, 6'h20, 0, 0, 1, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t3_add_r0", k, 0, 1, 0);
        tick();
        put(1, 6'h2B, 0, 2, 4, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t3_sw", k, 0, 1, 0);
        tick();
        put(1, 6'h23, 0, 4, 7, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t3_lw", k, 0, 1, 0);
        tick();
        drain();

        // T4: lw r8 ; beq r8,r9 stalled, flushed, then re-presented
        put(1, 6'h23, 0, 0, 8, 0, 0, 0);
        tick();
        put(1, 6'h04, 0, 8, 9, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t4_beq", k, 1, 0, 1);
        tick();
        put(1, 6'h04, 0, 8, 9, 0, 0, 1);
        for (int k = 0; k < N; k++) expect_out("t4_flush", k, 1, 0, 1);
        tick();
        put(1, 6'h04, 0, 8, 9, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("t4_busy_d%0d", k), 32'(o_busy[k]), 0);
            expect_out("t4_reissue", k, 0, 1, 0);
        end
        tick();
        drain();

        // T5: jal ; jr r31 frozen by ext_stall for 4 cycles
        put(1, 6'h03, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            put(1, 6'h00, 6'h08, 31, 0, 0, 1, 0);
            expect_out("t5_frozen", 0, 1, 0, 0);
            check("t5_busy_d0", 32'(o_busy[0]), 1);
            tick();
        end
        put(1, 6'h00, 6'h08, 31, 0, 0, 0, 0);
        expect_out("t5_r1", 0, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h08, 31, 0, 0, 0, 0);
        expect_out("t5_r2", 0, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h08, 31, 0, 0, 0, 0);
        expect_out("t5_r3", 0, 0, 1, 0);
        expect_out("t5_r3", 1, 1, 0, 1);
        tick();
        put(1, 6'h00, 6'h08, 31, 0, 0, 0, 0);
        expect_out("t5_r4", 1, 0, 1, 0);
        tick();
        drain();

        // T6: hazard held under ext_stall for 20 cycles; 4-bit counter saturates
        put(1, 6'h23, 0, 0, 8, 0, 0, 0);
        tick();
        repeat (20) begin
            put(1, 6'h04, 0, 8, 9, 0, 1, 0);
            tick();
        end
        put(1, 6'h04, 0, 8, 9, 0, 1, 0);
        check("t6_sat_d2", 32'(o_cnt[2]), 15);
        check("t6_busy_pre_d0", 32'(o_busy[0]), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("t6_rst_cnt_d%0d", k), 32'(o_cnt[k]), 0);
            check($sformatf("t6_rst_busy_d%0d", k), 32'(o_busy[k]), 0);
            check($sformatf("t6_rst_stall_d%0d", k), 32'(o_stall[k]), 1);
        end
        tick();
        put(1, 6'h04, 0, 8, 9, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t6_rst_beq", k, 0, 1, 0);
        tick();
        rst_n = 1'b1;
        put(1, 6'h08, 0, 0, 5, 0, 0, 0);
        for (int k = 0; k < N; k++) expect_out("t6_after", k, 0, 1, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
